// File: rtl/ad9945_pkg.sv
// Shared AD9945 config-link definitions: register addresses, field widths, responder FSM states.
// Pure declarations; no latency or flow control of its own.
package ad9945_pkg;

    localparam int unsigned OPER_A    = 0;
    localparam int unsigned CTRL_A    = 1;
    localparam int unsigned CLAMP_A   = 2;
    localparam int unsigned VGA_A     = 3;

    localparam int unsigned FRAME_LEN = 15;

    localparam int unsigned OPER_W    = 7;
    localparam int unsigned CTRL_W    = 7;
    localparam int unsigned CLAMP_W   = 8;
    localparam int unsigned VGA_W     = 10;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        OVERRUN,
        COMMIT
    } state_t;

endpackage

// File: rtl/ad9945_cfg_rx_if.sv
// Link pins and register-image/write-report outputs of the AD9945 config responder.
// err_cnt exists only when CFG_RX_ERR_CNT_EN is defined; no flow control on any signal.
interface ad9945_cfg_rx_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 12
);
    import ad9945_pkg::*;

    logic                SL;
    logic                SCK;
    logic                SDATA;
    logic [OPER_W-1:0]   Oper;
    logic [CTRL_W-1:0]   Ctrl;
    logic [CLAMP_W-1:0]  Clamp;
    logic [VGA_W-1:0]    VGA_Gain;
    logic                wr_valid;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                frame_err;
`ifdef CFG_RX_ERR_CNT_EN
    logic [7:0]          err_cnt;
`endif

    modport slave (
        input  SL, SCK, SDATA,
        output Oper, Ctrl, Clamp, VGA_Gain, wr_valid, wr_addr, wr_data, frame_err
`ifdef CFG_RX_ERR_CNT_EN
        , output err_cnt
`endif
    );

    modport master (
        output SL, SCK, SDATA,
        input  Oper, Ctrl, Clamp, VGA_Gain, wr_valid, wr_addr, wr_data, frame_err
`ifdef CFG_RX_ERR_CNT_EN
        , input err_cnt
`endif
    );

endinterface

// File: rtl/ad9945_cfg_rx_sync.sv
// Synchronizes SL/SCK/SDATA into the system clock and flags SL rise/fall and SCK rise.
// Latency SYNC_STAGES clocks to synced level, edge flags combinational off the last stage; no backpressure.
module cfg_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sl,
    input  logic sck,
    input  logic sdata,
    output logic sl_s,
    output logic sl_rise,
    output logic sl_fall,
    output logic sck_rise,
    output logic sdata_s
);

    logic [SYNC_STAGES-1:0] sl_sync_q, sl_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic                   sl_prev_q, sl_prev_d;
    logic                   sck_prev_q, sck_prev_d;

    always_comb begin
        sl_sync_d    = {sl_sync_q[SYNC_STAGES-2:0], sl};
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], sck};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
        sl_prev_d    = sl_sync_q[SYNC_STAGES-1];
        sck_prev_d   = sck_sync_q[SYNC_STAGES-1];
    end

    // Chains reset low so a frame already in flight at reset release never looks like a fresh SL fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_sync_q    <= '0;
            sck_sync_q   <= '0;
            sdata_sync_q <= '0;
            sl_prev_q    <= 1'b0;
            sck_prev_q   <= 1'b0;
        end else begin
            sl_sync_q    <= sl_sync_d;
            sck_sync_q   <= sck_sync_d;
            sdata_sync_q <= sdata_sync_d;
            sl_prev_q    <= sl_prev_d;
            sck_prev_q   <= sck_prev_d;
        end
    end

    assign sl_s     = sl_sync_q[SYNC_STAGES-1];
    assign sl_rise  =  sl_sync_q[SYNC_STAGES-1] & ~sl_prev_q;
    assign sl_fall  = ~sl_sync_q[SYNC_STAGES-1] &  sl_prev_q;
    assign sck_rise =  sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sdata_s  = sdata_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ad9945_cfg_rx.sv
// AD9945 3-wire config responder: deframes LSB-first writes into the register image; err_cnt via CFG_RX_ERR_CNT_EN.
// wr_valid lands SYNC_STAGES+2 clocks after the SL pin rises; no backpressure, SCK phases must be >= SYNC_STAGES+1 clocks.
module ad9945_cfg_rx
    import ad9945_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    ad9945_cfg_rx_if.slave cfg
);

    localparam int FL = ADDR_W + DATA_W;

    logic sl_s, sl_rise, sl_fall, sck_rise, sdata_s;

    cfg_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .sl       (cfg.SL),
        .sck      (cfg.SCK),
        .sdata    (cfg.SDATA),
        .sl_s     (sl_s),
        .sl_rise  (sl_rise),
        .sl_fall  (sl_fall),
        .sck_rise (sck_rise),
        .sdata_s  (sdata_s)
    );

    state_t              state_q, state_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [FL-1:0]       sr_q, sr_d;
    logic [OPER_W-1:0]   oper_q, oper_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [CLAMP_W-1:0]  clamp_q, clamp_d;
    logic [VGA_W-1:0]    vga_q, vga_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        oper_d      = oper_q;
        ctrl_d      = ctrl_q;
        clamp_d     = clamp_q;
        vga_d       = vga_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        case (state_q)
            WAIT_IDLE: if (sl_s) state_d = IDLE;
            IDLE: if (sl_fall) begin
                state_d   = SHIFT;
                bit_cnt_d = '0;
                sr_d      = '0;
            end
            // SL rise outranks a coincident SCK rise: that bit is dropped and the count decides the frame.
            SHIFT: if (sl_rise) begin
                if (bit_cnt_q == 5'(FL)) begin
                    state_d = COMMIT;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end else if (sck_rise) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'(FL)) state_d = OVERRUN;
                else                     sr_d    = {sdata_s, sr_q[FL-1:1]};
            end
            OVERRUN: if (sl_rise) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
            end
            COMMIT: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = sr_q[ADDR_W-1:0];
                wr_data_d  = sr_q[FL-1:ADDR_W];
                if (sr_q[ADDR_W-1:0] == ADDR_W'(OPER_A))  oper_d  = sr_q[ADDR_W +: OPER_W];
                if (sr_q[ADDR_W-1:0] == ADDR_W'(CTRL_A))  ctrl_d  = sr_q[ADDR_W +: CTRL_W];
                if (sr_q[ADDR_W-1:0] == ADDR_W'(CLAMP_A)) clamp_d = sr_q[ADDR_W +: CLAMP_W];
                if (sr_q[ADDR_W-1:0] == ADDR_W'(VGA_A))   vga_d   = sr_q[ADDR_W +: VGA_W];
                state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            oper_q      <= '0;
            ctrl_q      <= '0;
            clamp_q     <= '0;
            vga_q       <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            oper_q      <= oper_d;
            ctrl_q      <= ctrl_d;
            clamp_q     <= clamp_d;
            vga_q       <= vga_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef CFG_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) err_cnt_q <= '0;
        else            err_cnt_q <= err_cnt_d;
    end

    assign cfg.err_cnt = err_cnt_q;
`endif

    assign cfg.Oper      = oper_q;
    assign cfg.Ctrl      = ctrl_q;
    assign cfg.Clamp     = clamp_q;
    assign cfg.VGA_Gain  = vga_q;
    assign cfg.wr_valid  = wr_valid_q;
    assign cfg.wr_addr   = wr_addr_q;
    assign cfg.wr_data   = wr_data_q;
    assign cfg.frame_err = frame_err_q;

endmodule

// File: tb/tb_ad9945_cfg_rx.sv
// Randomized and directed frames against a frame-level model of the AD9945 config responder.
// Outputs compared every falling edge; err_cnt checked when CFG_RX_ERR_CNT_EN is defined.
module tb_ad9945_cfg_rx;
    import ad9945_pkg::*;

    localparam int S = 2;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    ad9945_cfg_rx_if #(.ADDR_W(3), .DATA_W(12)) cfg ();

    ad9945_cfg_rx #(.ADDR_W(3), .DATA_W(12), .SYNC_STAGES(S)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cfg       (cfg)
    );

    typedef struct {
        int         c;
        logic [2:0] a;
        logic [11:0] d;
    } ev_t;

    ev_t         evq[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0;
    int          err_seen = 0, valid_seen = 0, exp_err = 0, exp_err_rst = 0;
    int          last_valid_cyc = 0, last_slrise = 0;
    bit          ev_now;
    logic [6:0]  m_oper = '0, m_ctrl = '0;
    logic [7:0]  m_clamp = '0;
    logic [9:0]  m_vga = '0;
    logic [2:0]  m_addr = '0;
    logic [11:0] m_data = '0;

    always @(posedge sys_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame-level reference: a good write becomes visible exactly SYNC_STAGES+2 clocks after SL rises.
    always @(negedge sys_clk) begin
        ev_now = 1'b0;
        if (evq.size() > 0 && evq[0].c < cyc) begin
            check("missed_write", 32'(evq[0].c), 32'(cyc));
            void'(evq.pop_front());
        end
        if (evq.size() > 0 && evq[0].c == cyc) begin
            ev_now = 1'b1;
            case (evq[0].a)
                3'd0: m_oper  = evq[0].d[6:0];
                3'd1: m_ctrl  = evq[0].d[6:0];
                3'd2: m_clamp = evq[0].d[7:0];
                3'd3: m_vga   = evq[0].d[9:0];
                default: ;
            endcase
            m_addr = evq[0].a;
            m_data = evq[0].d;
            void'(evq.pop_front());
        end
        check("wr_valid", 32'(cfg.wr_valid), 32'(ev_now));
        check("wr_addr",  32'(cfg.wr_addr),  32'(m_addr));
        check("wr_data",  32'(cfg.wr_data),  32'(m_data));
        check("Oper",     32'(cfg.Oper),     32'(m_oper));
        check("Ctrl",     32'(cfg.Ctrl),     32'(m_ctrl));
        check("Clamp",    32'(cfg.Clamp),    32'(m_clamp));
        check("VGA_Gain", 32'(cfg.VGA_Gain), 32'(m_vga));
        if (cfg.frame_err === 1'b1) err_seen++;
        if (cfg.wr_valid === 1'b1) begin
            valid_seen++;
            last_valid_cyc = cyc;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input int nbits, input logic [14:0] bits, input int ph);
        int  e0;
        ev_t ev;
        e0 = err_seen;
        wait_cyc(1);
        cfg.SL = 1'b0;
        wait_cyc(ph);
        for (int i = 0; i < nbits; i++) begin
            cfg.SDATA = (i < 15) ? bits[i] : 1'($urandom);
            wait_cyc(ph);
            cfg.SCK = 1'b1;
            wait_cyc(ph);
            cfg.SCK = 1'b0;
        end
        wait_cyc(ph);
        cfg.SL = 1'b1;
        last_slrise = cyc;
        if (nbits == 15) begin
            ev.c = cyc + S + 2;
            ev.a = bits[2:0];
            ev.d = bits[14:3];
            evq.push_back(ev);
        end else begin
            exp_err++;
            exp_err_rst++;
        end
        wait_cyc(ph + S + 4);
        check("frame_err_pulses", 32'(err_seen - e0), (nbits == 15) ? 32'd0 : 32'd1);
    endtask

    initial begin
        int v0, e0, kind, nb, ph;
        cfg.SL    = 1'b1;
        cfg.SCK   = 1'b0;
        cfg.SDATA = 1'b0;
        wait_cyc(3);
        check("reset_wr_valid", 32'(cfg.wr_valid), 32'd0);
        check("reset_VGA_Gain", 32'(cfg.VGA_Gain), 32'd0);
        sys_rst_n = 1'b1;
        wait_cyc(S + 3);

        // 1: single VGA write
        v0 = valid_seen;
        send(15, {12'h2A5, 3'd3}, 8);
        check("t1_VGA_Gain", 32'(cfg.VGA_Gain), 32'h2A5);
        check("t1_Oper",     32'(cfg.Oper),     32'h0);
        check("t1_wr_addr",  32'(cfg.wr_addr),  32'd3);
        check("t1_pulses",   32'(valid_seen - v0), 32'd1);
        check("t1_latency",  32'(last_valid_cyc - last_slrise), 32'(S + 2));

        // 2: back-to-back writes
        v0 = valid_seen;
        send(15, {12'h07F, 3'd0}, 4);
        send(15, {12'h0C3, 3'd2}, 4);
        check("t2_Oper",   32'(cfg.Oper),  32'h7F);
        check("t2_Clamp",  32'(cfg.Clamp), 32'hC3);
        check("t2_pulses", 32'(valid_seen - v0), 32'd2);

        // 3: short frame
        v0 = valid_seen;
        send(9, 15'h5A5A, 5);
        check("t3_pulses",   32'(valid_seen - v0), 32'd0);
        check("t3_VGA_Gain", 32'(cfg.VGA_Gain), 32'h2A5);

        // 4: overrun, then recovery
        send(17, {12'h123, 3'd1}, 4);
        check("t4_Ctrl", 32'(cfg.Ctrl), 32'h0);
        send(15, {12'h055, 3'd1}, 3);
        check("t4_Ctrl_next", 32'(cfg.Ctrl), 32'h55);

        // 5: unmapped address
        v0 = valid_seen;
        send(15, {12'hFFF, 3'd6}, 4);
        check("t5_pulses",  32'(valid_seen - v0), 32'd1);
        check("t5_wr_addr", 32'(cfg.wr_addr), 32'd6);
        check("t5_wr_data", 32'(cfg.wr_data), 32'hFFF);
        check("t5_Oper",    32'(cfg.Oper),    32'h7F);
        check("t5_Clamp",   32'(cfg.Clamp),   32'hC3);

        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6)      nb = 15;
            else if (kind < 8) nb = $urandom_range(0, 14);
            else               nb = $urandom_range(16, 19);
            ph = $urandom_range(S + 1, 6);
            send(nb, 15'($urandom), ph);
        end

        // 6: reset mid-frame, released while SL is still low
        wait_cyc(1);
        cfg.SL = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 3; i++) begin
            cfg.SDATA = 1'($urandom);
            wait_cyc(4); cfg.SCK = 1'b1;
            wait_cyc(4); cfg.SCK = 1'b0;
        end
        sys_rst_n = 1'b0;
        m_oper = '0; m_ctrl = '0; m_clamp = '0; m_vga = '0; m_addr = '0; m_data = '0;
        evq.delete();
        exp_err_rst = 0;
        wait_cyc(3);
        check("t6_Oper_in_reset", 32'(cfg.Oper), 32'd0);
        sys_rst_n = 1'b1;
        v0 = valid_seen;
        e0 = err_seen;
        for (int i = 0; i < 12; i++) begin
            cfg.SDATA = 1'($urandom);
            wait_cyc(4); cfg.SCK = 1'b1;
            wait_cyc(4); cfg.SCK = 1'b0;
        end
        wait_cyc(4);
        cfg.SL = 1'b1;
        wait_cyc(S + 8);
        check("t6_ignored_valid", 32'(valid_seen - v0), 32'd0);
        check("t6_ignored_err",   32'(err_seen - e0),   32'd0);
        send(15, {12'h3C1, 3'd3}, 4);
        check("t6_VGA_Gain", 32'(cfg.VGA_Gain), 32'h3C1);

`ifdef CFG_RX_ERR_CNT_EN
        check("err_cnt_after_reset", 32'(cfg.err_cnt), 32'(exp_err_rst));
        for (int k = 0; k < 300; k++) send(0, 15'h0, S + 1);
        check("err_cnt_saturated", 32'(cfg.err_cnt), 32'd255);
`endif

        wait_cyc(10);
        check("writes_drained", 32'(evq.size()), 32'd0);
        check("err_total",      32'(err_seen),   32'(exp_err));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
